// File: rtl/sram_ctrl_pkg.sv
// Shared types and timing defaults for the synchronous SRAM front end.
// The counter width is sized from the longest phase so one timer serves all phases.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int DEF_ADDR_SIZE = 18;
  localparam int DEF_WORD_SIZE = 8;
  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_WR_PULSE  = 2;
  localparam int DEF_RD_WAIT   = 2;
  localparam int DEF_HOLD_CYC  = 1;

  function automatic int max_phase(input int s, input int w, input int r, input int h);
    int m;
    m = s;
    if (w > m) m = w;
    if (r > m) m = r;
    if (h > m) m = h;
    return m;
  endfunction

  // The timer is loaded with (length - 1), so clog2(length) bits suffice; never narrower than 1.
  function automatic int cnt_width(input int s, input int w, input int r, input int h);
    int m;
    m = max_phase(s, w, r, h);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  localparam int CNT_W = cnt_width(DEF_SETUP_CYC, DEF_WR_PULSE, DEF_RD_WAIT, DEF_HOLD_CYC);

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter; o_tc flags the final cycle of the phase currently loaded.
module sram_phase_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Synchronous request/response front end for an asynchronous SRAM.
// Every SRAM-side pin is driven straight from a flop so bCE/bWE cannot glitch.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int AddressSize = DEF_ADDR_SIZE,
  parameter int WordSize    = DEF_WORD_SIZE,
  parameter int SETUP_CYC   = DEF_SETUP_CYC,
  parameter int WR_PULSE    = DEF_WR_PULSE,
  parameter int RD_WAIT     = DEF_RD_WAIT,
  parameter int HOLD_CYC    = DEF_HOLD_CYC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [AddressSize-1:0] req_addr,
  input  logic [WordSize-1:0]    req_wdata,
  output logic                   rsp_valid,
  output logic [WordSize-1:0]    rsp_rdata,
  output logic [AddressSize-1:0] sram_addr,
  output logic [WordSize-1:0]    sram_wdata,
  input  logic [WordSize-1:0]    sram_rdata,
  output logic                   sram_bCE,
  output logic                   sram_bWE
);

  localparam int CntW = cnt_width(SETUP_CYC, WR_PULSE, RD_WAIT, HOLD_CYC);

  localparam logic [CntW-1:0] LD_SETUP = CntW'(SETUP_CYC - 1);
  localparam logic [CntW-1:0] LD_WR    = CntW'(WR_PULSE - 1);
  localparam logic [CntW-1:0] LD_RD    = CntW'(RD_WAIT - 1);
  localparam logic [CntW-1:0] LD_HOLD  = CntW'(HOLD_CYC - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_write;
  logic [AddressSize-1:0] r_addr;
  logic [WordSize-1:0]    r_wdata;
  logic                   r_bce;
  logic                   r_bwe;
  logic                   r_rsp_valid;
  logic [WordSize-1:0]    r_rsp_rdata;

  logic                   w_accept;
  logic                   w_tc;
  logic                   w_load;
  logic [CntW-1:0]        w_load_val;
  logic                   w_bce_next;
  logic                   w_bwe_next;
  logic                   w_rsp_valid_next;
  logic                   w_capture;

  assign w_accept = req_valid && (r_state == IDLE);

  sram_phase_timer #(
    .W (CntW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Each transition reloads the timer with the length of the phase being entered.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = SETUP;
          w_load       = 1'b1;
          w_load_val   = LD_SETUP;
        end
      end
      SETUP: begin
        if (w_tc) begin
          w_state_next = ACCESS;
          w_load       = 1'b1;
          w_load_val   = r_write ? LD_WR : LD_RD;
        end
      end
      ACCESS: begin
        if (w_tc) begin
          w_state_next = HOLD;
          w_load       = 1'b1;
          w_load_val   = LD_HOLD;
        end
      end
      HOLD: begin
        if (w_tc) begin
          w_state_next = IDLE;
          w_load       = 1'b1;
          w_load_val   = '0;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Pin values are decoded from the next state and registered, so they line up with r_state.
  always_comb begin
    w_bce_next       = !((w_state_next == SETUP) || (w_state_next == ACCESS));
    w_bwe_next       = !((w_state_next == ACCESS) && r_write);
    w_rsp_valid_next = (r_state == ACCESS) && (w_state_next == HOLD);
    w_capture        = w_rsp_valid_next && !r_write;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bce       <= 1'b1;
      r_bwe       <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_bce       <= w_bce_next;
      r_bwe       <= w_bwe_next;
      r_rsp_valid <= w_rsp_valid_next;
      if (w_capture) begin
        r_rsp_rdata <= sram_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;
  assign sram_bCE   = r_bce;
  assign sram_bWE   = r_bwe;

endmodule
